uart_top: RTL and testbench
===========================

UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 1000000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 9600, meaning the line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, 104 at defaults).
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port rx, input, 1 bit, serial receive line, idle high.
REQ-006 The module SHALL have port dintx, input, 8 bits, byte to transmit.
REQ-007 The module SHALL have port send, input, 1 bit, transmit request (level).
REQ-008 The module SHALL have port tx, output, 1 bit, serial transmit line, idle high.
REQ-009 The module SHALL have port doutrx, output, 8 bits, last correctly received byte.
REQ-010 The module SHALL have port donetx, output, 1 bit, one-clk pulse at frame transmit completion.
REQ-011 The module SHALL have port donerx, output, 1 bit, one-clk pulse when doutrx is updated.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit lasting CLKS_PER_BIT clk cycles.
REQ-013 The transmitter FSM SHALL use states IDLE, START, DATA, STOP; IDLE drives tx=1.
REQ-014 In IDLE, send=1 SHALL latch dintx into a shift register on the same edge and enter START; the first start-bit cycle is the next clk.
REQ-015 DATA SHALL shift out bits 0..7 with a 3-bit counter; changes to dintx after the latch SHALL NOT affect the frame in flight.
REQ-016 At the end of STOP, donetx SHALL pulse high for exactly one clk and the FSM SHALL return to IDLE.
REQ-017 If send is still high in IDLE, the next frame SHALL start immediately, giving back-to-back frames with no idle gap beyond one clk.
REQ-018 Send is ignored while a frame is in flight; no queuing.
REQ-019 The receiver SHALL synchronise rx through two flip-flops before use.
REQ-020 The receiver FSM SHALL use states IDLE, START, DATA, STOP.
REQ-021 A falling level (rx=0) in IDLE SHALL enter START; at CLKS_PER_BIT/2 the receiver SHALL re-check rx: if 0, enter DATA; if 1, treat as a glitch and return to IDLE.
REQ-022 DATA SHALL sample 8 bits at successive CLKS_PER_BIT intervals (mid-bit), LSB first.
REQ-023 In STOP at mid-bit: if rx=1, doutrx SHALL update and donerx SHALL pulse for one clk; if rx=0 (framing error), the byte SHALL be discarded, doutrx SHALL be held, no donerx SHALL occur, and the receiver SHALL wait for rx=1 before returning to IDLE.
REQ-024 Transmitter and receiver SHALL be independent and operate full-duplex simultaneously.

Reset
REQ-025 rst=0 SHALL asynchronously force tx=1, doutrx=0x00, donetx=0, donerx=0, both FSMs to IDLE, and all counters and shift registers to 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no done pulse; after release, a new frame SHALL start only on a fresh send or start bit.

Configuration
REQ-027 With macro UART_LOOPBACK_EN defined, the receiver input SHALL be the internal tx signal and the rx port SHALL be ignored.
REQ-028 Without UART_LOOPBACK_EN, the receiver SHALL use the rx port.

Verification
REQ-029 Transmit: reset, then dintx=0xA5, send=1 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 104 clks; donetx pulses once per frame.
REQ-030 Receive: drive rx = 0,1,0,1,0,0,1,0,1,1 at 104 clks per bit -> doutrx=0xA5 and one donerx pulse near mid stop bit.
REQ-031 Framing error: receive 0x3C with stop bit 0 -> no donerx pulse; doutrx keeps its previous value; a following valid 0x81 frame is received.
REQ-032 Glitch rejection: rx low for 20 clks, then high -> receiver stays IDLE, no donerx pulse.
REQ-033 Reset mid-transmit: rst=0 at data bit 3 -> tx=1 immediately and no donetx pulse; after rst=1 with send held, a full frame is sent.
REQ-034 Loopback (UART_LOOPBACK_EN defined): send 0x5A -> donerx pulses with doutrx=0x5A while the rx port is held at 0.

Source files
------------

// File: rtl/uart_top.sv
// 8N1 UART, independent full-duplex transmitter and receiver; timers are down-counters.
// Define UART_LOOPBACK_EN to feed the receiver from the internal tx line instead of rx.
module uart_top #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [7:0] dintx,
  input  logic       send,
  output logic       tx,
  output logic [7:0] doutrx,
  output logic       donetx,
  output logic       donerx
);
  // state | meaning (shared by both FSMs)
  // IDLE  | line idle; tx waits for send, rx waits for a low level
  // START | start bit; rx re-checks the line at mid-bit
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit; rx also parks here after a framing error until the line is high
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  state_t          tx_state, tx_state_n;
  logic [CW-1:0]   tx_cnt, tx_cnt_n;
  logic [2:0]      tx_bit, tx_bit_n;
  logic [7:0]      tx_shift, tx_shift_n;
  logic            tx_n, donetx_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      donetx   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx       <= tx_n;
      donetx   <= donetx_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    donetx_n   = 1'b0;
    case (tx_state)
      IDLE:
        if (send) begin
          tx_shift_n = dintx;
          tx_cnt_n   = BIT_LAST;
          tx_state_n = START;
        end
      START:
        if (tx_cnt == '0) begin
          tx_cnt_n   = BIT_LAST;
          tx_bit_n   = '0;
          tx_state_n = DATA;
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      DATA:
        if (tx_cnt == '0) begin
          tx_cnt_n   = BIT_LAST;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          if (tx_bit == 3'd7) tx_state_n = STOP;
          else                tx_bit_n   = tx_bit + 1'b1;
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      STOP:
        if (tx_cnt == '0) begin
          donetx_n   = 1'b1;
          tx_state_n = IDLE;
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      default: tx_state_n = IDLE;
    endcase
    // tx is registered from the next state so the line never glitches
    tx_n = 1'b1;
    if (tx_state_n == START)     tx_n = 1'b0;
    else if (tx_state_n == DATA) tx_n = tx_shift_n[0];
  end

  logic rx_src, rx_s1, rx_s2;
`ifdef UART_LOOPBACK_EN
  assign rx_src = tx;
`else
  assign rx_src = rx;
`endif

  state_t          rx_state, rx_state_n;
  logic [CW-1:0]   rx_cnt, rx_cnt_n;
  logic [2:0]      rx_bit, rx_bit_n;
  logic [7:0]      rx_shift, rx_shift_n;
  logic [7:0]      doutrx_n;
  logic            rx_err, rx_err_n, donerx_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // synchroniser resets to the idle level so reset release is not seen as a start bit
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_err   <= 1'b0;
      doutrx   <= '0;
      donerx   <= 1'b0;
    end else begin
      rx_s1    <= rx_src;
      rx_s2    <= rx_s1;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_err   <= rx_err_n;
      doutrx   <= doutrx_n;
      donerx   <= donerx_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_err_n   = rx_err;
    doutrx_n   = doutrx;
    donerx_n   = 1'b0;
    case (rx_state)
      IDLE:
        if (!rx_s2) begin
          rx_cnt_n   = HALF_LAST;
          rx_state_n = START;
        end
      START:
        if (rx_cnt == '0) begin
          if (!rx_s2) begin
            rx_cnt_n   = BIT_LAST;
            rx_bit_n   = '0;
            rx_state_n = DATA;
          end else begin
            rx_state_n = IDLE;
          end
        end else begin
          rx_cnt_n = rx_cnt - 1'b1;
        end
      DATA:
        if (rx_cnt == '0) begin
          rx_cnt_n   = BIT_LAST;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = STOP;
          else                rx_bit_n   = rx_bit + 1'b1;
        end else begin
          rx_cnt_n = rx_cnt - 1'b1;
        end
      STOP:
        if (rx_err) begin
          if (rx_s2) begin
            rx_err_n   = 1'b0;
            rx_state_n = IDLE;
          end
        end else if (rx_cnt == '0) begin
          if (rx_s2) begin
            doutrx_n   = rx_shift;
            donerx_n   = 1'b1;
            rx_state_n = IDLE;
          end else begin
            rx_err_n = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt - 1'b1;
        end
      default: rx_state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_top.sv
// Scoreboard bench for uart_top: stimulus pushes expected bytes, tx-line and donerx monitors pop and compare.
module tb_uart_top;
  localparam int CPB = 104;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       send = 1'b0;
  logic [7:0] dintx = 8'h00;
  logic       tx, donetx, donerx;
  logic [7:0] doutrx;

  int total = 0;
  int passed = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  uart_top #(.CLK_FREQ(1000000), .BAUD_RATE(9600)) dut (
    .clk(clk), .rst(rst), .rx(rx), .dintx(dintx), .send(send),
    .tx(tx), .doutrx(doutrx), .donetx(donetx), .donerx(donerx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // decodes frames off the tx line, sampling each bit at its middle
  initial begin : tx_mon
    int mcnt;
    bit act;
    logic [9:0] fr;
    mcnt = 0;
    act = 1'b0;
    fr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        act = 1'b0;
      end else begin
        if (!act && tx === 1'b0) begin
          act = 1'b1;
          mcnt = 0;
        end else if (act) begin
          mcnt++;
        end
        if (act && (mcnt % CPB) == CPB/2 && mcnt < 10*CPB) fr[mcnt/CPB] = tx;
        if (donetx && !(act && mcnt == 10*CPB)) chk("donetx_spurious", 1, 0);
        if (act && mcnt == 10*CPB) begin
          chk("donetx_pulse", donetx, 1);
          chk("tx_start_bit", fr[0], 0);
          chk("tx_stop_bit", fr[9], 1);
          if (exp_tx.size() == 0) chk("tx_unexpected_frame", 1, 0);
          else chk("tx_byte", fr[8:1], exp_tx.pop_front());
          act = 1'b0;
        end
      end
    end
  end

  initial begin : rx_mon
    forever begin
      @(negedge clk);
      if (rst && donerx) begin
        if (exp_rx.size() == 0) chk("donerx_unexpected", 1, 0);
        else chk("doutrx", doutrx, exp_rx.pop_front());
      end
    end
  end

  task automatic drive_rx(input logic [7:0] b, input logic stopb);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopb;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_tx(input int lim);
    int n;
    n = 0;
    while (exp_tx.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("tx_frames_pending", exp_tx.size(), 0);
  endtask

  task automatic wait_rx(input int lim);
    int n;
    n = 0;
    while (exp_rx.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("rx_frames_pending", exp_rx.size(), 0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_doutrx", doutrx, 8'h00);
    chk("reset_donetx", donetx, 0);
    chk("reset_donerx", donerx, 0);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);

`ifdef UART_LOOPBACK_EN
    rx = 1'b0;
    dintx = 8'h5A;
    send = 1'b1;
    exp_tx.push_back(8'h5A);
    exp_rx.push_back(8'h5A);
    @(negedge clk) send = 1'b0;
    wait_tx(1200);
    wait_rx(200);
`else
    // single frame; dintx changes after the latch must not leak into it
    dintx = 8'hA5;
    send = 1'b1;
    exp_tx.push_back(8'hA5);
    @(negedge clk);
    send = 1'b0;
    dintx = 8'hFF;
    wait_tx(1200);

    // back-to-back frames with send held
    dintx = 8'h3C;
    send = 1'b1;
    exp_tx.push_back(8'h3C);
    exp_tx.push_back(8'hC3);
    repeat (5) @(negedge clk);
    dintx = 8'hC3;
    repeat (1050) @(negedge clk);
    send = 1'b0;
    wait_tx(1200);

    // receive, framing error, glitch rejection
    exp_rx.push_back(8'hA5);
    drive_rx(8'hA5, 1'b1);
    wait_rx(50);
    drive_rx(8'h3C, 1'b0);
    repeat (200) @(negedge clk);
    chk("doutrx_hold_after_framing_error", doutrx, 8'hA5);
    exp_rx.push_back(8'h81);
    drive_rx(8'h81, 1'b1);
    wait_rx(50);
    repeat (10) @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    chk("doutrx_hold_after_glitch", doutrx, 8'h81);
    exp_rx.push_back(8'hF0);
    drive_rx(8'hF0, 1'b1);
    wait_rx(50);

    // full duplex
    repeat (10) @(negedge clk);
    fork
      begin
        dintx = 8'h96;
        send = 1'b1;
        exp_tx.push_back(8'h96);
        @(negedge clk) send = 1'b0;
      end
      begin
        exp_rx.push_back(8'h69);
        drive_rx(8'h69, 1'b1);
      end
    join
    wait_tx(1200);
    wait_rx(50);

    // reset during data bit 3; the aborted frame must leave no trace
    repeat (10) @(negedge clk);
    dintx = 8'hE7;
    send = 1'b1;
    repeat (450) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("tx_high_on_reset", tx, 1);
    chk("donetx_low_on_reset", donetx, 0);
    repeat (5) @(negedge clk);
    dintx = 8'h42;
    exp_tx.push_back(8'h42);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send = 1'b0;
    wait_tx(1200);
`endif

    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
